// File: rtl/contador_ascendente_pkg.sv
// Shared types and constants for the up-counter and its hex display decoder.
package contador_pkg;

  // Counter control states.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low seven-segment glyphs, bit6=a .. bit0=g, indexed by hex digit.
  localparam logic [6:0] HEX_7SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Glyph for one hex digit.
  function automatic logic [6:0] hex_glyph(input logic [3:0] digit);
    return HEX_7SEG[digit];
  endfunction

endpackage

// File: rtl/contador_ascendente_hex_a_7seg.sv
// Combinational 4-bit hex digit to active-low seven-segment decoder.
module hex_a_7seg
  import contador_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure table lookup; no state.
  always_comb begin
    seg = hex_glyph(digit);
  end

endmodule

// File: rtl/contador_ascendente.sv
// Up-counter driven by a push button: loads a terminal value, counts button
// presses from 0 up to that value and shows the count on two hex digits.
// Optional build macro: CONTADOR_ASCENDENTE_WRAP_EN -- when defined, a press
// in DONE restarts the count from 0 (unless the loaded limit is 0).
//
// The button is asynchronous and active-low; it is brought into the clk
// domain by a two-flop synchronizer, and a press is the falling edge seen
// between the synchronizer output and a one-cycle delayed copy. From the
// first edge that samples inc=0, the count changes on the third edge.
module contador_ascendente
  import contador_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num,
  input  logic             inc,
  output logic [6:0]       seg1,
  output logic [6:0]       seg2,
  output logic             done
);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             press;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] limit_next;
  logic [7:0]       count_ext;

  // Button synchronizer and edge history; reset to "released" (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= inc;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press     = prev & ~sync2;
  assign count_inc = count + WIDTH'(1);

  // State, count and limit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      count <= '0;
      limit <= '0;
    end else begin
      state <= next_state;
      count <= count_next;
      limit <= limit_next;
    end
  end

  // Next-state logic: LOAD captures num once, COUNT advances on each press
  // until the limit is reached, DONE holds the count at the limit.
  always_comb begin
    next_state = state;
    count_next = count;
    limit_next = limit;
    case (state)
      LOAD: begin
        limit_next = num;
        count_next = '0;
        next_state = (num == '0) ? DONE : COUNT;
      end
      COUNT: begin
        if (press) begin
          count_next = count_inc;
          if (count_inc == limit) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
`ifdef CONTADOR_ASCENDENTE_WRAP_EN
        if (press && (limit != '0)) begin
          count_next = '0;
          next_state = COUNT;
        end
`endif
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  assign done = (state == DONE);

  // Zero-extend the count to two hex digits for the display.
  always_comb begin
    count_ext               = '0;
    count_ext[WIDTH-1:0]    = count;
  end

  hex_a_7seg u_digit_lo (
    .digit (count_ext[3:0]),
    .seg   (seg1)
  );

  hex_a_7seg u_digit_hi (
    .digit (count_ext[7:4]),
    .seg   (seg2)
  );

endmodule

// File: tb/tb_contador_ascendente.sv
// Bench for contador_ascendente: reference model pushes expected display
// changes (with the cycle they must appear) into a queue; a monitor pops an
// entry each time the DUT display/done changes and compares.
module tb_contador_ascendente;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] num;
  logic             inc;
  logic [6:0]       seg1;
  logic [6:0]       seg2;
  logic             done;

  contador_ascendente #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .num  (num),
    .inc  (inc),
    .seg1 (seg1),
    .seg2 (seg2),
    .done (done)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Glyph table for the model (active-low, a..g).
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [14:0] disp_of(input int c, input bit d);
    logic [7:0] v;
    v = c[7:0];
    return {glyph[v[7:4]], glyph[v[3:0]], d};
  endfunction

  // ---------------- reference model ----------------
  int          m_count  = 0;
  int          m_limit  = 0;
  bit          m_loaded = 0;
  logic [14:0] m_disp;
  logic [46:0] exp_q[$];   // {cycle[31:0], seg2, seg1, done}

  function automatic bit m_done();
    return m_loaded && (m_count == m_limit);
  endfunction

  task automatic push_if_changed(input int at);
    logic [14:0] nd;
    nd = disp_of(m_count, m_done());
    if (nd != m_disp) begin
      exp_q.push_back({at[31:0], nd});
      m_disp = nd;
    end
  endtask

  task automatic model_press(input int at);
    if (m_loaded) begin
      if (m_count < m_limit) m_count++;
`ifdef CONTADOR_ASCENDENTE_WRAP_EN
      else if (m_limit != 0) m_count = 0;
`endif
    end
    push_if_changed(at);
  endtask

  // ---------------- monitor ----------------
  bit          mon_en = 0;
  logic [14:0] seen;

  always @(negedge clk) begin
    logic [14:0] cur;
    logic [46:0] e;
    #1;
    if (mon_en) begin
      cur = {seg2, seg1, done};
      if (cur !== seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", {49'd0, cur}, {49'd0, seen});
        end else begin
          e = exp_q.pop_front();
          check("disp", {49'd0, cur}, {49'd0, e[14:0]});
          check("disp_cycle", 64'(cyc), {32'd0, e[46:15]});
        end
        seen = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Assert reset mid-cycle, check the asynchronous clear, then release.
  task automatic do_reset(input logic [WIDTH-1:0] n, input bit hold_low);
    int rel;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    num      = n;
    m_count  = 0;
    m_limit  = 0;
    m_loaded = 0;
    push_if_changed(cyc);
    #1;
    check("rst_seg1", {57'd0, seg1}, {57'd0, 7'b0000001});
    check("rst_seg2", {57'd0, seg2}, {57'd0, 7'b0000001});
    check("rst_done", {63'd0, done}, 64'd0);
    if (hold_low) inc = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    rel      = cyc;
    m_limit  = int'(n);
    m_loaded = 1;
    push_if_changed(rel + 1);
    if (hold_low) model_press(rel + 3);
  endtask

  // One press: inc low for 'hold' cycles, then high for 'gap' cycles.
  task automatic press(input int hold, input int gap);
    @(negedge clk);
    inc = 1'b0;
    model_press(cyc + 3);
    repeat (hold) @(negedge clk);
    inc = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int np;
    rst    = 1'b1;
    inc    = 1'b1;
    num    = 6'h3F;
    m_disp = disp_of(0, 0);
    repeat (2) @(negedge clk);
    #1;
    seen   = {seg2, seg1, done};
    mon_en = 1;

    // Reset state and "still 00" one clock after release.
    do_reset(6'h3F, 0);
    @(negedge clk);
    #2;
    check("post_rel_seg1", {57'd0, seg1}, {57'd0, 7'b0000001});
    check("post_rel_seg2", {57'd0, seg2}, {57'd0, 7'b0000001});
    check("post_rel_done", {63'd0, done}, 64'd0);

    // Single press held for 12 cycles: exactly one increment.
    press(12, 3);

    // num=3: three presses then an extra one in DONE.
    do_reset(6'd3, 0);
    repeat (4) press(2, 2);

    // num=0: done right after LOAD, presses do nothing.
    do_reset(6'd0, 0);
    repeat (2) press(1, 2);

    // 18 presses toward 0x3F, then a mid-cycle reset (inside do_reset).
    do_reset(6'h3F, 0);
    repeat (18) press(1, 1);
    repeat (2) @(negedge clk);
    #2;
    check("show_12_seg1", {57'd0, seg1}, {57'd0, 7'b0010010});
    check("show_12_seg2", {57'd0, seg2}, {57'd0, 7'b1001111});

    // inc held low across reset release yields one press after LOAD.
    do_reset(6'd5, 1);
    repeat (4) @(negedge clk);
    inc = 1'b1;
    repeat (2) @(negedge clk);
    press(1, 1);

    // Wrap behaviour (or absorbing DONE in the default build).
    do_reset(6'd2, 0);
    repeat (3) press(2, 2);

    // Randomized trials.
    for (int t = 0; t < 8; t++) begin
      n  = $urandom_range(0, 63);
      np = $urandom_range(0, (n < 20) ? n + 2 : 20);
      do_reset(n[WIDTH-1:0], 0);
      for (int p = 0; p < np; p++) begin
        press($urandom_range(1, 4), $urandom_range(1, 3));
      end
    end

    repeat (6) @(negedge clk);
    #2;
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
